// File: rtl/requan_pipe_if.sv
// requan_pipe_if: beat-stream bundle for requan_pipe.
// Input side: in_valid/in_ready/in_ch/in_data; output side: out_valid/out_ready/out_data/out_sat.
interface requan_pipe_if #(
    parameter int LANES = 4,
    parameter int IN_W  = 16,
    parameter int OUT_W = 16,
    parameter int CH_W  = 3
);
    logic                   in_valid;
    logic                   in_ready;
    logic [CH_W-1:0]        in_ch;
    logic [LANES*IN_W-1:0]  in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*OUT_W-1:0] out_data;
    logic [LANES-1:0]       out_sat;

    modport master (
        output in_valid, in_ch, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_ch, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/requan_pipe.sv
// requan_pipe: 2-stage multi-lane requantiser (bias subtract, rounding shift, saturate).
// Ports: clk, rst (async high), cfg_we/cfg_addr/cfg_bias (bias table), cfg_shift, do_requan,
// bus (slave: in_valid/in_ready/in_ch/in_data, out_valid/out_ready/out_data/out_sat).
// Optional REQUAN_SAT_CNT_EN: adds sat_cnt_clr input and 32-bit sat_cnt output.
module requan_pipe #(
    parameter int LANES    = 4,
    parameter int IN_W     = 16,
    parameter int OUT_W    = 16,
    parameter int CH_DEPTH = 8,
    parameter int CH_W     = $clog2(CH_DEPTH),
    parameter int SH_W     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_we,
    input  logic [CH_W-1:0]        cfg_addr,
    input  logic signed [IN_W-1:0] cfg_bias,
    input  logic [SH_W-1:0]        cfg_shift,
    input  logic                   do_requan,
`ifdef REQUAN_SAT_CNT_EN
    input  logic                   sat_cnt_clr,
    output logic [31:0]            sat_cnt,
`endif
    requan_pipe_if.slave           bus
);
    localparam int DW = IN_W + 1;
    localparam int RW = IN_W + 2;
    localparam logic signed [RW-1:0] SAT_MAX =
        {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [RW-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [IN_W-1:0] bias_q [CH_DEPTH];
    logic signed [IN_W-1:0] bias_rd;

    logic                 s1_v;
    logic signed [DW-1:0] s1_diff [LANES];
    logic [SH_W-1:0]      s1_sh;
    logic signed [DW-1:0] diff_d [LANES];

    logic                     s2_v;
    logic [LANES*OUT_W-1:0]   out_q;
    logic [LANES-1:0]         sat_q;
    logic [LANES*OUT_W-1:0]   out_d;
    logic [LANES-1:0]         sat_d;

    logic s2_load;
    logic accept;

    assign s2_load      = !s2_v || bus.out_ready;
    assign bus.in_ready = !s1_v || s2_load;
    assign accept       = bus.in_valid && bus.in_ready;

    assign bus.out_valid = s2_v;
    assign bus.out_data  = out_q;
    assign bus.out_sat   = sat_q;

    // Addresses outside the table match no entry: writes drop, reads give 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CH_DEPTH; i++) bias_q[i] <= '0;
        end else if (cfg_we) begin
            for (int i = 0; i < CH_DEPTH; i++)
                if (cfg_addr == CH_W'(i)) bias_q[i] <= cfg_bias;
        end
    end

    always_comb begin
        bias_rd = '0;
        for (int i = 0; i < CH_DEPTH; i++)
            if (bus.in_ch == CH_W'(i)) bias_rd = bias_q[i];
    end

    // Bypass folds into the same path: no bias, zero shift.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            logic signed [IN_W-1:0] lane;
            lane = bus.in_data[l*IN_W +: IN_W];
            if (do_requan)
                diff_d[l] = {lane[IN_W-1], lane} - {bias_rd[IN_W-1], bias_rd};
            else
                diff_d[l] = {lane[IN_W-1], lane};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v  <= 1'b0;
            s1_sh <= '0;
            for (int l = 0; l < LANES; l++) s1_diff[l] <= '0;
        end else begin
            if (bus.in_ready) s1_v <= bus.in_valid;
            if (accept) begin
                s1_sh <= do_requan ? cfg_shift : '0;
                for (int l = 0; l < LANES; l++) s1_diff[l] <= diff_d[l];
            end
        end
    end

    always_comb begin
        out_d = '0;
        sat_d = '0;
        for (int l = 0; l < LANES; l++) begin
            logic signed [RW-1:0] ext;
            logic signed [RW-1:0] rnd;
            logic signed [RW-1:0] r;
            ext = {s1_diff[l][DW-1], s1_diff[l]};
            rnd = (s1_sh == '0) ? '0 : (RW'(1) << (s1_sh - SH_W'(1)));
            r   = (ext + rnd) >>> s1_sh;
            if (r > SAT_MAX) begin
                out_d[l*OUT_W +: OUT_W] = SAT_MAX[OUT_W-1:0];
                sat_d[l] = 1'b1;
            end else if (r < SAT_MIN) begin
                out_d[l*OUT_W +: OUT_W] = SAT_MIN[OUT_W-1:0];
                sat_d[l] = 1'b1;
            end else begin
                out_d[l*OUT_W +: OUT_W] = r[OUT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_v  <= 1'b0;
            out_q <= '0;
            sat_q <= '0;
        end else if (s2_load) begin
            s2_v <= s1_v;
            if (s1_v) begin
                out_q <= out_d;
                sat_q <= sat_d;
            end
        end
    end

`ifdef REQUAN_SAT_CNT_EN
    localparam int PW = $clog2(LANES + 1);
    logic [PW-1:0] pop;
    logic [32:0]   cnt_sum;

    always_comb begin
        pop = '0;
        for (int l = 0; l < LANES; l++) pop = pop + PW'(sat_q[l]);
        cnt_sum = {1'b0, sat_cnt} + 33'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sat_cnt <= '0;
        else if (sat_cnt_clr)
            sat_cnt <= '0;
        else if (s2_v && bus.out_ready)
            sat_cnt <= cnt_sum[32] ? '1 : cnt_sum[31:0];
    end
`endif
endmodule
